// File: rtl/x_parity_encoder.sv
`timescale 1ns/1ps
// x_parity_encoder
//
// Transmit-side companion to the serial H-row parity checker. Collects J-1
// information elements serially, inserts one parity element at position P_IDX
// and presents the packed J*AWIDTH word on the checker's x bus. Parity is even
// over the LSBs of the elements selected by the loaded H row.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   H, H_tvalid         parity-check row and its load strobe (taken at word boundary)
//   s_data, s_valid,    information element stream; s_ready drops only while the
//   s_ready             last element of a word would overwrite an unaccepted x
//   x, x_tvalid,        packed output word, element j at [j*AWIDTH +: AWIDTH],
//   x_tready            held until accepted
//   x_unsat             word built while H[P_IDX]==0, parity not enforceable
//   h_drop              one-cycle pulse: H_tvalid ignored because it arrived mid-word
module x_parity_encoder #(
  parameter int unsigned J     = 14,
  parameter int unsigned A     = 2,
  parameter int unsigned P_IDX = J - 1,
  localparam int unsigned AWIDTH  = $clog2(A) + 1,
  localparam int unsigned J_WIDTH = $clog2(J) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [J-1:0]          H,
  input  logic                  H_tvalid,
  input  logic [AWIDTH-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [J*AWIDTH-1:0]   x,
  output logic                  x_tvalid,
  input  logic                  x_tready,
  output logic                  x_unsat,
  output logic                  h_drop
);

  localparam logic [J_WIDTH-1:0] KLast = J_WIDTH'(J - 2);
  localparam logic [J_WIDTH-1:0] PIdxW = J_WIDTH'(P_IDX);

  logic [J-1:0]          h_q, h_d, h_eff;
  logic [J_WIDTH-1:0]    k_q, k_d, pos;
  logic                  par_q, par_d, par_bit, pf;
  logic [J*AWIDTH-1:0]   asm_q, asm_d;
  logic [J*AWIDTH-1:0]   x_q, x_d;
  logic                  x_tvalid_q, x_tvalid_d;
  logic                  x_unsat_q, x_unsat_d;
  logic                  h_drop_q, h_drop_d;
  logic                  h_load, last, accept;

  always_comb begin
    h_load  = H_tvalid && (k_q == '0);
    // A row loaded with the first element already governs that element.
    h_eff   = h_load ? H : h_q;
    last    = (k_q == KLast);
    s_ready = !(last && x_tvalid_q && !x_tready);
    accept  = s_valid && s_ready;

    // Info slots skip over the parity position. Written as k+1 > P_IDX so the
    // compare stays meaningful when P_IDX is 0.
    pos = ((k_q + 1'b1) > PIdxW) ? k_q + 1'b1 : k_q;

    par_bit = 1'b0;
    for (int unsigned j = 0; j < J; j++) begin
      if (pos == J_WIDTH'(j)) par_bit = h_eff[j] & s_data[0];
    end
    pf = h_eff[P_IDX] ? (par_q ^ par_bit) : 1'b0;

    h_d        = h_eff;
    h_drop_d   = H_tvalid && !h_load;
    k_d        = k_q;
    par_d      = par_q;
    asm_d      = asm_q;
    x_d        = x_q;
    x_unsat_d  = x_unsat_q;
    x_tvalid_d = x_tvalid_q && !x_tready;

    if (accept) begin
      for (int unsigned j = 0; j < J; j++) begin
        if (pos == J_WIDTH'(j)) asm_d[j*AWIDTH +: AWIDTH] = s_data;
      end
      if (last) begin
        // s_ready guarantees the previous word has been (or is being) taken.
        x_d                           = asm_d;
        x_d[P_IDX*AWIDTH +: AWIDTH]   = AWIDTH'(pf);
        x_unsat_d                     = ~h_eff[P_IDX];
        x_tvalid_d                    = 1'b1;
        k_d                           = '0;
        par_d                         = 1'b0;
      end else begin
        k_d   = k_q + 1'b1;
        par_d = par_q ^ par_bit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q        <= '0;
      k_q        <= '0;
      par_q      <= 1'b0;
      asm_q      <= '0;
      x_q        <= '0;
      x_tvalid_q <= 1'b0;
      x_unsat_q  <= 1'b0;
      h_drop_q   <= 1'b0;
    end else begin
      h_q        <= h_d;
      k_q        <= k_d;
      par_q      <= par_d;
      asm_q      <= asm_d;
      x_q        <= x_d;
      x_tvalid_q <= x_tvalid_d;
      x_unsat_q  <= x_unsat_d;
      h_drop_q   <= h_drop_d;
    end
  end

  assign x        = x_q;
  assign x_tvalid = x_tvalid_q;
  assign x_unsat  = x_unsat_q;
  assign h_drop   = h_drop_q;

endmodule

// File: tb/tb_x_parity_encoder.sv
`timescale 1ns/1ps
// Bench for x_parity_encoder: P_IDX=J-1 instance driven through a scoreboard,
// plus a P_IDX=0 instance checked directly.
module tb_x_parity_encoder;

  localparam int J  = 14;
  localparam int AW = 2;
  localparam int XW = J * AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [J-1:0]  h;
  logic          h_tvalid;
  logic [AW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [XW-1:0] x;
  logic          x_tvalid, x_tready, x_unsat, h_drop;

  logic [J-1:0]  h_p0;
  logic          h_tvalid_p0;
  logic [AW-1:0] s_data_p0;
  logic          s_valid_p0;
  logic          s_ready_p0;
  logic [XW-1:0] x_p0;
  logic          x_tvalid_p0, x_tready_p0, x_unsat_p0, h_drop_p0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  int n_words  = 0;
  logic [XW:0] exp_q[$];
  logic [XW:0] mon_exp;

  x_parity_encoder #(.J(J), .A(2), .P_IDX(J-1)) dut (
    .clk(clk), .rst_n(rst_n), .H(h), .H_tvalid(h_tvalid),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .x(x), .x_tvalid(x_tvalid), .x_tready(x_tready),
    .x_unsat(x_unsat), .h_drop(h_drop)
  );

  x_parity_encoder #(.J(J), .A(2), .P_IDX(0)) dut_p0 (
    .clk(clk), .rst_n(rst_n), .H(h_p0), .H_tvalid(h_tvalid_p0),
    .s_data(s_data_p0), .s_valid(s_valid_p0), .s_ready(s_ready_p0),
    .x(x_p0), .x_tvalid(x_tvalid_p0), .x_tready(x_tready_p0),
    .x_unsat(x_unsat_p0), .h_drop(h_drop_p0)
  );

  // Scoreboard consumer: every output handshake pops one expected {unsat, x}.
  always @(negedge clk) begin
    if (rst_n && x_tvalid && x_tready) begin
      n_out++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got x=%h unsat=%b, required no word", x, x_unsat);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({x_unsat, x} !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_word: got unsat=%b x=%h, required unsat=%b x=%h",
                   x_unsat, x, mon_exp[XW], mon_exp[XW-1:0]);
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: place info elements around slot p, then fill slot p with parity.
  function automatic logic [XW:0] model(input logic [J-1:0] hv, input logic [AW-1:0] e [J-1],
                                        input int p);
    logic [XW-1:0] w;
    logic          par;
    int            pos;
    w   = '0;
    par = 1'b0;
    for (int i = 0; i < J - 1; i++) begin
      pos = (i < p) ? i : i + 1;
      w[pos*AW +: AW] = e[i];
      par = par ^ (hv[pos] & e[i][0]);
    end
    if (hv[p]) w[p*AW] = par;
    return {~hv[p], w};
  endfunction

  // Entry/exit point: #1 after a posedge. Returns #1 after the accepting edge.
  task automatic send_elem(input logic [AW-1:0] d);
    int t;
    t = 0;
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, t);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [J-1:0] hv, input bit load_h, input logic [AW-1:0] e [J-1],
                           input logic [XW:0] expw, input bit chk_lat);
    exp_q.push_back(expw);
    n_words++;
    for (int i = 0; i < J - 1; i++) begin
      if (i == 0 && load_h) begin
        h        = hv;
        h_tvalid = 1'b1;
      end
      if (i == J - 2 && chk_lat) begin
        n_checks++;
        if (x_tvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL lat_pre: x_tvalid=%b before last element, required 0", x_tvalid);
        end
      end
      send_elem(e[i]);
      h_tvalid = 1'b0;
      if (i == J - 2 && chk_lat) begin
        n_checks++;
        if (x_tvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL lat_post: x_tvalid=%b one cycle after last accept, required 1", x_tvalid);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; h = '0; h_tvalid = 1'b0; s_data = '0; s_valid = 1'b0; x_tready = 1'b1;
    h_p0 = '0; h_tvalid_p0 = 1'b0; s_data_p0 = '0; s_valid_p0 = 1'b0; x_tready_p0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({x_tvalid, x_unsat, h_drop, s_ready} !== 4'b0001 || x !== '0) begin
      n_fail++;
      $display("FAIL reset_state: tvalid/unsat/drop/ready=%b%b%b%b x=%h, required 0001 x=0",
               x_tvalid, x_unsat, h_drop, s_ready, x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [AW-1:0] e [J-1];
    x_tready = 1'b1;
    for (int i = 0; i < J - 1; i++) e[i] = 2'b01;
    send_word(14'h3FFF, 1'b1, e, {1'b0, 28'h5555555}, 1'b1);
    for (int i = 0; i < J - 1; i++) e[i] = 2'b10;
    send_word(14'h3FFF, 1'b1, e, {1'b0, 28'h2AAAAAA}, 1'b1);
    for (int i = 0; i < J - 1; i++) e[i] = 2'b01;
    send_word(14'h1FFF, 1'b1, e, {1'b1, 28'h1555555}, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_pidx0();
    n_checks++;
    if (s_ready_p0 !== 1'b1) begin
      n_fail++;
      $display("FAIL p0_ready: s_ready=%b, required 1", s_ready_p0);
    end
    h_p0 = 14'h0003; h_tvalid_p0 = 1'b1; s_data_p0 = 2'b01; s_valid_p0 = 1'b1;
    @(posedge clk);
    #1;
    h_tvalid_p0 = 1'b0;
    s_data_p0   = 2'b00;
    for (int i = 1; i < J - 1; i++) begin
      if (i == J - 2) begin
        n_checks++;
        if (x_tvalid_p0 !== 1'b0) begin
          n_fail++;
          $display("FAIL p0_early: x_tvalid=%b before last element, required 0", x_tvalid_p0);
        end
      end
      @(posedge clk);
      #1;
    end
    s_valid_p0 = 1'b0;
    n_checks++;
    if ({x_tvalid_p0, x_unsat_p0} !== 2'b10 || x_p0 !== 28'h0000005) begin
      n_fail++;
      $display("FAIL p0_word: tvalid=%b unsat=%b x=%h, required 1 0 x=0000005",
               x_tvalid_p0, x_unsat_p0, x_p0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ea [J-1];
    logic [AW-1:0] eb [J-1];
    logic [XW:0]   expa, expb;
    for (int i = 0; i < J - 1; i++) begin
      ea[i] = AW'(i % 4);
      eb[i] = AW'((i * 7 + 1) % 4);
    end
    expa = model(14'h2A5F, ea, J - 1);
    expb = model(14'h2A5F, eb, J - 1);
    x_tready = 1'b0;
    send_word(14'h2A5F, 1'b1, ea, expa, 1'b0);
    exp_q.push_back(expb);
    n_words++;
    for (int i = 0; i < J - 2; i++) begin
      n_checks++;
      if (s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_ready_early: s_ready=%b at k=%0d, required 1", s_ready, i);
      end
      send_elem(eb[i]);
    end
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (s_ready !== 1'b0 || x_tvalid !== 1'b1 || {x_unsat, x} !== expa) begin
      n_fail++;
      $display("FAIL bp_hold: ready=%b tvalid=%b x=%h, required 0 1 x=%h",
               s_ready, x_tvalid, x, expa[XW-1:0]);
    end
    x_tready = 1'b1;
    send_elem(eb[J-2]);
    n_checks++;
    if (x_tvalid !== 1'b1 || {x_unsat, x} !== expb) begin
      n_fail++;
      $display("FAIL bp_release: tvalid=%b x=%h, required 1 x=%h", x_tvalid, x, expb[XW-1:0]);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || x_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: pending=%0d tvalid=%b, required 0 0", exp_q.size(), x_tvalid);
    end
  endtask

  task automatic test_hdrop_reset();
    logic [AW-1:0] e [J-1];
    for (int i = 0; i < J - 1; i++) e[i] = AW'((i * 3) % 4);
    x_tready = 1'b0;
    exp_q.push_back(model(14'h3FFF, e, J - 1));
    n_words++;
    for (int i = 0; i < J - 1; i++) begin
      if (i == 0) begin h = 14'h3FFF; h_tvalid = 1'b1; end
      if (i == 5) begin h = 14'h0000; h_tvalid = 1'b1; end
      send_elem(e[i]);
      h_tvalid = 1'b0;
      if (i == 5 || i == 6) begin
        n_checks++;
        if (h_drop !== (i == 5)) begin
          n_fail++;
          $display("FAIL h_drop_k%0d: h_drop=%b, required %b", i, h_drop, (i == 5));
        end
      end
    end
    // Word C now pending; start D and reset at k=7.
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin h = 14'h3FFF; h_tvalid = 1'b1; end
      send_elem(2'b11);
      h_tvalid = 1'b0;
    end
    // C is checked here directly; the reset below discards it.
    n_checks++;
    if (x_tvalid !== 1'b1 || {x_unsat, x} !== exp_q[0]) begin
      n_fail++;
      $display("FAIL old_h_word: tvalid=%b x=%h unsat=%b, required 1 x=%h unsat=%b",
               x_tvalid, x, x_unsat, exp_q[0][XW-1:0], exp_q[0][XW]);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (x_tvalid !== 1'b0 || x !== '0 || s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: tvalid=%b x=%h ready=%b, required 0 0 1", x_tvalid, x, s_ready);
    end
    n_words = n_words - exp_q.size();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    x_tready = 1'b1;
    for (int i = 0; i < J - 1; i++) e[i] = AW'((i * 5 + 2) % 4);
    send_word(14'h3C3C, 1'b1, e, model(14'h3C3C, e, J - 1), 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [AW-1:0] e [J-1];
    logic [J-1:0]  hv;
    x_tready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      hv = J'($urandom);
      for (int i = 0; i < J - 1; i++) e[i] = AW'($urandom_range(3, 0));
      send_word(hv, 1'b1, e, model(hv, e, J - 1), 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || n_out != n_words) begin
      n_fail++;
      $display("FAIL word_count: outputs=%0d pending=%0d, required outputs=%0d pending=0",
               n_out, exp_q.size(), n_words);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pidx0();
    test_back_to_back();
    test_hdrop_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
